// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access.
// Ports: clk, reset (asynchronous, active-low);
//   fetch side  ireq/iaddr/iabort in, irdata/iready out;
//   data side   dreq/dwe/daddr/dwdata in, drdata/dready out;
//   memory side mreq/mwe/maddr/mwdata out, mrdata/mack in;
//   err: sticky timeout flag.
// The optional timeout watchdog is enabled by defining MEMARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int MAXDATA = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  input  logic        iabort,
  output logic [31:0] irdata,
  output logic        iready,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        mreq,
  output logic        mwe,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mack,
  output logic        err
);
  localparam int SW = ($clog2(MAXDATA + 1) > 3) ? $clog2(MAXDATA + 1) : 3;
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} stateT;
  stateT state, nextState;
  logic [SW-1:0] streak;
  logic dropFlag, iElig, dElig, grantD, grantI, drop, done, tmo;
  // A requester whose ready pulse is showing is still holding its old
  // request, so it must not be granted again in that cycle.
  always_comb begin
    iElig = ireq && !iready;
    dElig = dreq && !dready;
    grantD = (state == IDLE) && dElig && !(iElig && streak == SW'(MAXDATA));
    grantI = (state == IDLE) && iElig && !grantD;
    drop = dropFlag || iabort;
    done = (state != IDLE) && (mack || tmo);
    nextState = grantD ? DBUSY : grantI ? IBUSY : done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mreq <= 1'b0;
      mwe <= 1'b0;
      maddr <= '0;
      mwdata <= '0;
      irdata <= '0;
      drdata <= '0;
      iready <= 1'b0;
      dready <= 1'b0;
      streak <= '0;
      dropFlag <= 1'b0;
    end else begin
      iready <= 1'b0;
      dready <= 1'b0;
      if (grantD || grantI) begin
        mreq <= 1'b1;
        maddr <= grantD ? daddr : iaddr;
        mwe <= grantD && dwe;
      end
      if (grantD) mwdata <= dwdata;
      if (grantI) streak <= '0;
      else if (grantD) streak <= !ireq ? '0 : (streak == SW'(MAXDATA)) ? streak : streak + 1'b1;
      if (grantI) dropFlag <= iabort;
      else if (state == IBUSY) dropFlag <= drop;
      if (done) begin
        mreq <= 1'b0;
        dropFlag <= 1'b0;
        if (state == IBUSY) begin
          // A dropped fetch still records returned data, but a timed-out
          // dropped fetch leaves irdata alone.
          if (mack || !drop) irdata <= mack ? mrdata : 32'hDEADBEEF;
          iready <= !drop;
        end else begin
          if (!mwe) drdata <= mack ? mrdata : 32'hDEADBEEF;
          dready <= 1'b1;
        end
      end
    end
`ifdef MEMARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] busyCnt;
  logic errFlag;
  // busyCnt holds (busy cycles elapsed - 1); expiry fires in the last allowed cycle.
  assign tmo = (state != IDLE) && !mack && busyCnt == TW'(TIMEOUT - 1);
  assign err = errFlag;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busyCnt <= '0;
      errFlag <= 1'b0;
    end else begin
      busyCnt <= (state == IDLE) ? '0 : busyCnt + 1'b1;
      errFlag <= errFlag || tmo;
    end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ireq = 1'b0, iabort = 1'b0, dreq = 1'b0, dwe = 1'b0, mack = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0, mrdata = '0;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic iready, dready, mreq, mwe, err;
  int total = 0;
  int bad = 0;

  mem_arbiter #(.MAXDATA(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .iabort(iabort), .irdata(irdata), .iready(iready),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .dready(dready),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata), .mrdata(mrdata), .mack(mack),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkIdleOuts(input string tag);
    chk({tag, " mreq"}, 32'(mreq), 32'd0);
    chk({tag, " mwe"}, 32'(mwe), 32'd0);
    chk({tag, " maddr"}, maddr, 32'd0);
    chk({tag, " mwdata"}, mwdata, 32'd0);
    chk({tag, " irdata"}, irdata, 32'd0);
    chk({tag, " drdata"}, drdata, 32'd0);
    chk({tag, " iready"}, 32'(iready), 32'd0);
    chk({tag, " dready"}, 32'(dready), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
  endtask

  initial begin
    step();
    step();
    chkIdleOuts("reset");
    reset = 1'b1;
    step();
    // fetch, zero-wait
    ireq = 1'b1; iaddr = 32'h00400000;
    step();
    chk("f0 mreq", 32'(mreq), 32'd1);
    chk("f0 maddr", maddr, 32'h00400000);
    chk("f0 mwe", 32'(mwe), 32'd0);
    chk("f0 iready early", 32'(iready), 32'd0);
    mack = 1'b1; mrdata = 32'h20080005;
    step();
    mack = 1'b0;
    chk("f0 iready", 32'(iready), 32'd1);
    chk("f0 irdata", irdata, 32'h20080005);
    chk("f0 mreq low", 32'(mreq), 32'd0);
    ireq = 1'b0;
    step();
    chk("f0 single pulse", 32'(iready), 32'd0);
    // collision: data first, then fetch right after dready
    ireq = 1'b1; iaddr = 32'h00400004;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h10010000;
    step();
    chk("col mreq", 32'(mreq), 32'd1);
    chk("col data first", maddr, 32'h10010000);
    mack = 1'b1; mrdata = 32'h12345678;
    step();
    mack = 1'b0;
    chk("col dready", 32'(dready), 32'd1);
    chk("col drdata", drdata, 32'h12345678);
    chk("col no iready", 32'(iready), 32'd0);
    chk("col mreq gap", 32'(mreq), 32'd0);
    dreq = 1'b0;
    step();
    chk("col fetch mreq", 32'(mreq), 32'd1);
    chk("col fetch addr", maddr, 32'h00400004);
    mack = 1'b1; mrdata = 32'h24020001;
    step();
    mack = 1'b0;
    chk("col iready", 32'(iready), 32'd1);
    chk("col irdata", irdata, 32'h24020001);
    chk("col drdata kept", drdata, 32'h12345678);
    ireq = 1'b0;
    step();
    // starvation guard: four data grants while fetch waits, then fetch
    iaddr = 32'h00400008;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h10010004;
    for (int k = 1; k <= 4; k++) begin
      ireq = 1'b1;
      step();
      chk($sformatf("stv grant%0d mreq", k), 32'(mreq), 32'd1);
      chk($sformatf("stv grant%0d data", k), maddr, 32'h10010004);
      mack = 1'b1; mrdata = 32'(k);
      step();
      mack = 1'b0;
      chk($sformatf("stv dready%0d", k), 32'(dready), 32'd1);
      chk($sformatf("stv drdata%0d", k), drdata, 32'(k));
      ireq = 1'b0;
      step();
    end
    ireq = 1'b1;
    step();
    chk("stv forced fetch mreq", 32'(mreq), 32'd1);
    chk("stv forced fetch addr", maddr, 32'h00400008);
    mack = 1'b1; mrdata = 32'h11111111;
    step();
    mack = 1'b0;
    chk("stv fetch iready", 32'(iready), 32'd1);
    step();
    chk("stv restart data", maddr, 32'h10010004);
    chk("stv restart mreq", 32'(mreq), 32'd1);
    mack = 1'b1; mrdata = 32'h55AA55AA;
    step();
    mack = 1'b0;
    chk("stv restart dready", 32'(dready), 32'd1);
    dreq = 1'b0; ireq = 1'b0;
    step();
    chk("stv dready single", 32'(dready), 32'd0);
    // abort during wait cycles
    ireq = 1'b1; iaddr = 32'h0040000C;
    step();
    chk("ab1 mreq", 32'(mreq), 32'd1);
    step();
    iabort = 1'b1;
    step();
    iabort = 1'b0;
    step();
    mack = 1'b1; mrdata = 32'hAAAA5555;
    step();
    mack = 1'b0;
    chk("ab1 no iready", 32'(iready), 32'd0);
    chk("ab1 irdata", irdata, 32'hAAAA5555);
    chk("ab1 mreq low", 32'(mreq), 32'd0);
    iaddr = 32'h00400100;
    step();
    chk("ab1 next grant", maddr, 32'h00400100);
    mack = 1'b1; mrdata = 32'h0BADF00D;
    step();
    mack = 1'b0;
    chk("ab1 next iready", 32'(iready), 32'd1);
    chk("ab1 next irdata", irdata, 32'h0BADF00D);
    ireq = 1'b0;
    step();
    // abort coincident with mack
    ireq = 1'b1; iaddr = 32'h00400104;
    step();
    chk("ab2 mreq", 32'(mreq), 32'd1);
    mack = 1'b1; iabort = 1'b1; mrdata = 32'h13572468;
    step();
    mack = 1'b0; iabort = 1'b0;
    chk("ab2 no iready", 32'(iready), 32'd0);
    chk("ab2 irdata", irdata, 32'h13572468);
    ireq = 1'b0;
    step();
    chk("ab2 no late iready", 32'(iready), 32'd0);
    // store with two wait cycles
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h10010008; dwdata = 32'hCAFEF00D;
    for (int w = 0; w < 3; w++) begin
      step();
      chk($sformatf("st mreq%0d", w), 32'(mreq), 32'd1);
      chk($sformatf("st mwe%0d", w), 32'(mwe), 32'd1);
      chk($sformatf("st mwdata%0d", w), mwdata, 32'hCAFEF00D);
      chk($sformatf("st maddr%0d", w), maddr, 32'h10010008);
    end
    mack = 1'b1; mrdata = 32'hFFFFFFFF;
    step();
    mack = 1'b0;
    chk("st dready", 32'(dready), 32'd1);
    chk("st drdata kept", drdata, 32'h55AA55AA);
    dreq = 1'b0; dwe = 1'b0;
    step();
    chk("st dready single", 32'(dready), 32'd0);
    // asynchronous reset in the middle of a data transfer
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h1001000C; dwdata = 32'h87654321;
    step();
    chk("rst busy mreq", 32'(mreq), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chkIdleOuts("rst async");
    dreq = 1'b0; dwe = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rst abandoned", 32'(mreq), 32'd0);
`ifdef MEMARB_TIMEOUT_EN
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h10010010;
    step();
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("to wait%0d dready", i), 32'(dready), 32'd0);
      step();
    end
    chk("to last cycle mreq", 32'(mreq), 32'd1);
    step();
    chk("to dready", 32'(dready), 32'd1);
    chk("to drdata", drdata, 32'hDEADBEEF);
    chk("to err", 32'(err), 32'd1);
    chk("to mreq low", 32'(mreq), 32'd0);
    dreq = 1'b0;
    step();
    mack = 1'b1; mrdata = 32'h01234567;
    step();
    mack = 1'b0;
    chk("to late mack dready", 32'(dready), 32'd0);
    chk("to late mack drdata", drdata, 32'hDEADBEEF);
    chk("to err sticky", 32'(err), 32'd1);
    reset = 1'b0;
    #1;
    chk("to err cleared", 32'(err), 32'd0);
    step();
    reset = 1'b1;
`else
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h10010010;
    for (int i = 0; i < 12; i++) step();
    chk("nto still waiting", 32'(mreq), 32'd1);
    chk("nto no dready", 32'(dready), 32'd0);
    chk("nto err", 32'(err), 32'd0);
    mack = 1'b1; mrdata = 32'h0F0F0F0F;
    step();
    mack = 1'b0; dreq = 1'b0;
    chk("nto dready", 32'(dready), 32'd1);
    chk("nto drdata", drdata, 32'h0F0F0F0F);
`endif
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
